// File: rtl/uart_pixel_loader.sv
// UART byte-stream parser feeding the TFT/SDRAM frame controller: decodes load/show
// commands, packs byte pairs into RGB565 words, buffers them and tracks the write address.
module uart_pixel_loader #(
    parameter int         H_ACTIVE = 800,
    parameter int         V_ACTIVE = 480,
    parameter int         FIFO_AW  = 4,
    parameter logic [7:0] HDR_LOAD = 8'hA5,
    parameter logic [7:0] HDR_SHOW = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        fifo_rd_req,
    input  logic        wr_inc,
    output logic [15:0] fifo_out,
    output logic        fifo_avail,
    output logic [2:0]  page_set,
    output logic [2:0]  page_show,
    output logic [8:0]  row_add_user,
    output logic [9:0]  col_add_user,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_PAGE, S_SHOW_PAGE, S_PIX_HI, S_PIX_LO, S_DRAIN
    } state_t;

    localparam int             DEPTH     = 1 << FIFO_AW;
    localparam logic [18:0]    FRAME_PIX = 19'(H_ACTIVE * V_ACTIVE);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    state_t       r_state;
    logic [7:0]   r_hi;
    logic [18:0]  r_pix_cnt;
    logic [2:0]   r_page_set;
    logic [2:0]   r_page_show;
    logic [8:0]   r_row;
    logic [9:0]   r_col;
    logic         r_frame_busy;
    logic         r_frame_done;
    logic         r_overflow;

    logic [15:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic [15:0]        r_fifo_out;

    logic               w_pix_strobe;
    logic               w_load_strobe;
    logic [15:0]        w_word;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_overflow_evt;
    logic [FIFO_AW-1:0] w_rd_ptr_next;
    logic [18:0]        w_pix_cnt_inc;
    logic               w_pix_last;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_wrap;

    assign w_pix_strobe   = rx_valid && (r_state == S_PIX_LO);
    assign w_load_strobe  = rx_valid && (r_state == S_LOAD_PAGE);
    assign w_word         = {r_hi, rx_data};
    assign w_full         = (r_count == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push         = w_pix_strobe && (!w_full || fifo_rd_req);
    assign w_pop          = fifo_rd_req && (r_count != '0);
    assign w_overflow_evt = w_pix_strobe && w_full && !fifo_rd_req;
    assign w_rd_ptr_next  = r_rd_ptr + FIFO_AW'(w_pop);

    assign w_pix_cnt_inc  = r_pix_cnt + 19'd1;
    assign w_pix_last     = (w_pix_cnt_inc == FRAME_PIX);
    assign w_col_last     = (r_col == 10'(H_ACTIVE - 1));
    assign w_row_last     = (r_row == 9'(V_ACTIVE - 1));
    assign w_wrap         = wr_inc && w_col_last && w_row_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_hi         <= '0;
            r_pix_cnt    <= '0;
            r_page_set   <= '0;
            r_page_show  <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (wr_inc) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 9'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
            // Assignments below override the address advance when a load begins.
            if (rx_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == HDR_LOAD) begin
                            r_state <= S_LOAD_PAGE;
                        end else if (rx_data == HDR_SHOW) begin
                            r_state <= S_SHOW_PAGE;
                        end
                    end
                    S_LOAD_PAGE: begin
                        r_page_set   <= rx_data[2:0];
                        r_row        <= '0;
                        r_col        <= '0;
                        r_overflow   <= 1'b0;
                        r_frame_busy <= 1'b1;
                        r_pix_cnt    <= '0;
                        r_state      <= S_PIX_HI;
                    end
                    S_SHOW_PAGE: begin
                        r_page_show <= rx_data[2:0];
                        r_state     <= S_IDLE;
                    end
                    S_PIX_HI: begin
                        r_hi    <= rx_data;
                        r_state <= S_PIX_LO;
                    end
                    S_PIX_LO: begin
                        r_pix_cnt <= w_pix_cnt_inc;
                        r_state   <= w_pix_last ? S_DRAIN : S_PIX_HI;
                    end
                    default: begin
                    end
                endcase
            end
            if ((r_state == S_DRAIN) && w_wrap) begin
                r_frame_busy <= 1'b0;
                r_state      <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fifo_out <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + FIFO_AW'(w_push);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= r_count + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
            // Head register: bypass the new word when it becomes the head, otherwise
            // advance to the next stored word on a pop; hold when the FIFO runs empty.
            if (w_push && (r_count == (FIFO_AW + 1)'(w_pop))) begin
                r_fifo_out <= w_word;
            end else if (w_pop && (r_count != (FIFO_AW + 1)'(1))) begin
                r_fifo_out <= r_mem[w_rd_ptr_next];
            end
        end
    end

    assign fifo_out     = r_fifo_out;
    assign fifo_avail   = (r_count != '0);
    assign page_set     = r_page_set;
    assign page_show    = r_page_show;
    assign row_add_user = r_row;
    assign col_add_user = r_col;
    assign frame_busy   = r_frame_busy;
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Directed-plus-random bench for uart_pixel_loader, checked every cycle against a
// queue/linear-address reference model of the command stream.
module tb_uart_pixel_loader;

    localparam int H     = 20;
    localparam int V     = 3;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NPIX  = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        fifo_rd_req = 1'b0;
    logic        wr_inc = 1'b0;
    logic [15:0] fifo_out;
    logic        fifo_avail;
    logic [2:0]  page_set;
    logic [2:0]  page_show;
    logic [8:0]  row_add_user;
    logic [9:0]  col_add_user;
    logic        frame_busy;
    logic        frame_done;
    logic        overflow;

    uart_pixel_loader #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .FIFO_AW  (AW),
        .HDR_LOAD (8'hA5),
        .HDR_SHOW (8'h5A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .fifo_rd_req  (fifo_rd_req),
        .wr_inc       (wr_inc),
        .fifo_out     (fifo_out),
        .fifo_avail   (fifo_avail),
        .page_set     (page_set),
        .page_show    (page_show),
        .row_add_user (row_add_user),
        .col_add_user (col_add_user),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: mode 0 idle, 1 awaiting load page, 2 awaiting show page,
    // 3 receiving pixel bytes, 4 waiting for the address to wrap.
    logic [15:0] m_q[$];
    logic [15:0] m_last;
    int          m_mode;
    bit          m_half;
    logic [7:0]  m_hi;
    int          m_pix;
    int          m_addr;
    logic [2:0]  m_pset, m_pshow;
    logic        m_busy, m_done, m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_last = '0; m_mode = 0; m_half = 0; m_hi = '0; m_pix = 0; m_addr = 0;
        m_pset = '0; m_pshow = '0; m_busy = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s at %0t: observed %0h required %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fifo_avail", 32'(fifo_avail), 32'(m_q.size() > 0));
        chk("fifo_out", 32'(fifo_out), 32'(m_last));
        chk("page_set", 32'(page_set), 32'(m_pset));
        chk("page_show", 32'(page_show), 32'(m_pshow));
        chk("row", 32'(row_add_user), 32'(m_addr / H));
        chk("col", 32'(col_add_user), 32'(m_addr % H));
        chk("frame_busy", 32'(frame_busy), 32'(m_busy));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic rd, input logic inc);
        int pre_mode, pre_size;
        logic wrap;
        rx_valid = v; rx_data = d; fifo_rd_req = rd; wr_inc = inc;
        pre_mode = m_mode; pre_size = m_q.size(); wrap = 1'b0;
        if (rst) begin
            if (inc) begin
                if (m_addr == NPIX - 1) begin m_addr = 0; wrap = 1'b1; end
                else m_addr++;
            end
            m_done = wrap;
            if (rd && pre_size > 0) void'(m_q.pop_front());
            if (v) begin
                case (pre_mode)
                    0: if (d == 8'hA5) m_mode = 1; else if (d == 8'h5A) m_mode = 2;
                    1: begin
                        m_pset = d[2:0]; m_addr = 0; m_ovf = 0; m_busy = 1;
                        m_pix = 0; m_half = 0; m_mode = 3;
                    end
                    2: begin m_pshow = d[2:0]; m_mode = 0; end
                    3: begin
                        if (!m_half) begin
                            m_hi = d; m_half = 1;
                        end else begin
                            m_half = 0;
                            if (pre_size < DEPTH || rd) m_q.push_back({m_hi, d});
                            else m_ovf = 1;
                            m_pix++;
                            if (m_pix == NPIX) m_mode = 4;
                        end
                    end
                    default: ;
                endcase
            end
            if (pre_mode == 4 && wrap) begin m_busy = 0; m_mode = 0; end
            if (m_q.size() > 0) m_last = m_q[0];
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0; fifo_rd_req = 1'b0; wr_inc = 1'b0;
        check_all();
    endtask

    task automatic pix(input logic [15:0] w, input logic rd_lo);
        step(1'b1, w[15:8], 1'b0, 1'b0);
        step(1'b1, w[7:0], rd_lo, 1'b0);
    endtask

    task automatic rand_frame(input int npix);
        for (int k = 0; k < npix; k++) begin
            step(1'b1, 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            step(1'b1, 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic drain_frame();
        for (int k = 0; k < 4 * NPIX && m_busy; k++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checked %0d)", n_total);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;

        // Page select, with a stray byte ignored in idle
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h06, 1'b0, 1'b0);

        // Packing and show-ahead pops
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        pix(16'h1234, 1'b0);
        pix(16'hABCD, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-frame with 3 words queued and a partial pixel
        for (int k = 0; k < 3; k++) pix(16'($urandom), 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        rst = 1'b0;
        #2;
        model_reset();
        check_all();
        step(1'b1, 8'hA5, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);

        // Address advance in idle through a full wrap
        for (int k = 0; k < NPIX + 1; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Overflow: 17 pixels without pops, then push+pop on full, drain, push+pop on empty
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) pix(16'($urandom), 1'b0);
        pix(16'($urandom), 1'b1);
        for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
        pix(16'($urandom), 1'b1);
        rand_frame(NPIX - DEPTH - 3);
        drain_frame();

        // Next frame load clears overflow; random frame with bytes ignored while draining
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h05, 1'b0, 1'b0);
        rand_frame(NPIX);
        drain_frame();
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_pixel_loader.md
Name: uart_pixel_loader

Overview:
- Upstream feeder for the TFT/SDRAM frame controller.
- Parses the UART receive byte stream into frame-load and page-select commands, and packs byte pairs into RGB565 pixel words.
- Buffers pixels in a show-ahead FIFO that the frame controller drains.
- Supplies the SDRAM write page/row/column address; the address advances on each write-complete pulse from the frame controller.

Parameters:
H_ACTIVE, 800, pixels per line; col_add_user wraps at H_ACTIVE-1
V_ACTIVE, 480, lines per frame; row_add_user wraps at V_ACTIVE-1
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words
HDR_LOAD, 8'hA5, command byte: frame load
HDR_SHOW, 8'h5A, command byte: select displayed page

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
fifo_rd_req  in  1  pop head word (from frame controller)
wr_inc  in  1  one-cycle pulse: SDRAM word written, advance address
fifo_out  out  16  head FIFO word (show-ahead)
fifo_avail  out  1  FIFO not empty
page_set  out  3  page being loaded
page_show  out  3  page selected for display
row_add_user  out  9  write row address
col_add_user  out  10  write column address
frame_busy  out  1  frame load in progress
frame_done  out  1  one-cycle pulse: last pixel of frame written to SDRAM
overflow  out  1  sticky: pixel dropped because FIFO full

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE.
- All registers clock on posedge clk; asynchronous clear on rst low. Reset mid-frame discards FIFO contents and any partial pixel.
- FSM states: IDLE, LOAD_PAGE, SHOW_PAGE, PIX_HI, PIX_LO, DRAIN. Transitions occur only on cycles where rx_valid=1, except DRAIN.
- IDLE:
  - rx_data==HDR_LOAD -> LOAD_PAGE.
  - rx_data==HDR_SHOW -> SHOW_PAGE.
  - Any other byte is ignored; stay in IDLE.
- LOAD_PAGE:
  - page_set<=rx_data[2:0]; row/col <= 0; overflow <= 0; frame_busy<=1; pixel count <= 0 -> PIX_HI.
- SHOW_PAGE:
  - page_show<=rx_data[2:0] -> IDLE.
  - Updating page_show during a load is not possible, since SHOW_PAGE is reachable only from IDLE.
- PIX_HI: latch rx_data as the high byte -> PIX_LO.
- PIX_LO:
  - Form word {hi, rx_data}. Push it if the FIFO is not full; if full, drop the word and set overflow.
  - Increment pixel count. At count == H_ACTIVE*V_ACTIVE go to DRAIN, otherwise go to PIX_HI.
- DRAIN: wait for the address to wrap (last wr_inc of the frame), then frame_busy<=0 -> IDLE. Bytes arriving during DRAIN are ignored.
- FIFO:
  - Show-ahead: fifo_out is valid whenever fifo_avail=1.
  - A push is visible on fifo_out/fifo_avail one cycle after the PIX_LO strobe.
  - A pop on fifo_rd_req takes effect at the next edge.
  - Simultaneous push and pop on a full FIFO: the push is accepted and count is unchanged.
  - Simultaneous push and pop on an empty FIFO: the push is accepted; the pop is ignored.
  - A pop while empty is ignored, and fifo_out holds its last value.
  - Pointers wrap modulo the depth.
- Address counters:
  - wr_inc increments col_add_user. At col==H_ACTIVE-1, col goes to 0 and row increments.
  - At row==V_ACTIVE-1 and col==H_ACTIVE-1, both go to 0 and frame_done pulses for 1 cycle, registered on the same edge.
  - wr_inc in IDLE still advances the address.
  - When wr_inc coincides with the LOAD_PAGE strobe, LOAD_PAGE's clear to 0 wins.
- Pixel count: 19 bits, unsigned. Compare against H_ACTIVE*V_ACTIVE, computed at elaboration.

Test Plan:
- Reset: assert rst=0 mid-frame with 3 words queued -> all outputs 0, fifo_avail=0; after release, FSM in IDLE.
- Page select: bytes 5A,06 -> page_show=3'd6 two strobes later; page_set unchanged; frame_busy stays 0.
- Packing: bytes A5,02,12,34,AB,CD with no pops -> page_set=2, frame_busy=1, fifo_out=16'h1234 with fifo_avail=1; after 1 pop, fifo_out=16'hABCD; after 2nd pop, fifo_avail=0.
- Overflow: 17 pixels with FIFO_AW=4 and no pops -> 16 words held, overflow=1, 17th pixel absent; next A5 header clears overflow.
- Address wrap: 799 wr_inc -> col=799,row=0; 1 more -> col=0,row=1. With H_ACTIVE=4, V_ACTIVE=2: 8 wr_inc -> frame_done pulses exactly once, row=col=0, FSM returns to IDLE after DRAIN.
- Simultaneous push/pop: hold FIFO full, PIX_LO strobe with fifo_rd_req=1 -> occupancy stays 16, no overflow, word order preserved.
